// File: rtl/pc_fetch_unit.sv
// Program-counter register and instruction-fetch sequencer: holds PC, runs the
// instruction-memory request handshake and halts on ebreak, misalignment or timeout.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned EXEC_CYCLES = 2,
    parameter int unsigned MAX_WAIT    = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] PCNext,
    input  logic        stall,
    input  logic        imemReady,
    input  logic [31:0] instrIn,
    output logic [31:0] PC,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    output logic [31:0] instruction,
    output logic        instrValid,
    output logic [31:0] retired,
    output logic        misaligned,
    output logic        timeout,
    output logic        halted
);

    localparam logic [31:0] EBREAK    = 32'h0010_0073;
    localparam logic [3:0]  EXEC_LAST = 4'(EXEC_CYCLES - 1);
    localparam logic [7:0]  WAIT_LAST = 8'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_EXEC,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;
    logic        valid_q, valid_d;
    logic        mis_q, mis_d;
    logic        to_q, to_d;
    logic [7:0]  wait_q, wait_d;
    logic [3:0]  exec_q, exec_d;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        valid_d   = 1'b0;
        mis_d     = mis_q;
        to_d      = to_q;
        // The wait counter only survives while staying in REQ, so it is clear on every entry.
        wait_d    = '0;
        exec_d    = exec_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end

            S_REQ: begin
                if (imemReady) begin
                    instr_d = instrIn;
                    if (instrIn == EBREAK) begin
                        state_d = S_HALT;
                    end else begin
                        valid_d = 1'b1;
                        exec_d  = '0;
                        state_d = S_EXEC;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    to_d    = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            S_EXEC: begin
                if (exec_q == EXEC_LAST && !stall) begin
                    if (PCNext[1:0] != 2'b00) begin
                        mis_d   = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        pc_d      = PCNext;
                        retired_d = retired_q + 32'd1;
                        state_d   = S_REQ;
                    end
                end else if (exec_q != EXEC_LAST) begin
                    exec_d = exec_q + 4'd1;
                end
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            retired_q <= '0;
            valid_q   <= 1'b0;
            mis_q     <= 1'b0;
            to_q      <= 1'b0;
            wait_q    <= '0;
            exec_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            valid_q   <= valid_d;
            mis_q     <= mis_d;
            to_q      <= to_d;
            wait_q    <= wait_d;
            exec_q    <= exec_d;
        end
    end

    assign PC          = pc_q;
    assign imemAddr    = pc_q;
    assign imemReq     = (state_q == S_REQ);
    assign halted      = (state_q == S_HALT);
    assign instruction = instr_q;
    assign instrValid  = valid_q;
    assign retired     = retired_q;
    assign misaligned  = mis_q;
    assign timeout     = to_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: randomized fetch/execute transactions
// checked against a transaction-level model of PC, retired count and flags.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int unsigned EXEC_N = 2;
    localparam int unsigned WAIT_N = 15;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] PCNext;
    logic        stall;
    logic        imemReady;
    logic [31:0] instrIn;
    logic [31:0] PC;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] instruction;
    logic        instrValid;
    logic [31:0] retired;
    logic        misaligned;
    logic        timeout;
    logic        halted;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Transaction-level model state
    logic [31:0] m_pc;
    logic [31:0] m_retired;
    logic [31:0] m_instr;
    logic        m_mis;
    logic        m_to;

    pc_fetch_unit #(
        .RESET_PC   (RST_PC),
        .EXEC_CYCLES(EXEC_N),
        .MAX_WAIT   (WAIT_N)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .PCNext     (PCNext),
        .stall      (stall),
        .imemReady  (imemReady),
        .instrIn    (instrIn),
        .PC         (PC),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .instruction(instruction),
        .instrValid (instrValid),
        .retired    (retired),
        .misaligned (misaligned),
        .timeout    (timeout),
        .halted     (halted)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] v;
        v = $urandom;
        if (v == EBREAK) v = v ^ 32'h1;
        return v;
    endfunction

    // Holds reset for n_edges edges, checks reset outputs, then releases and enters REQ.
    task automatic test_reset(input int unsigned n_edges);
        reset     = 1'b0;
        imemReady = 1'($urandom_range(0, 1));
        instrIn   = $urandom;
        PCNext    = $urandom;
        stall     = 1'($urandom_range(0, 1));
        for (int unsigned i = 0; i < n_edges; i++) tick();
        m_pc = RST_PC; m_retired = '0; m_instr = '0; m_mis = 1'b0; m_to = 1'b0;
        n_checks++;
        if ({PC, imemAddr, imemReq, instruction, instrValid, retired, misaligned, timeout, halted}
            !== {m_pc, m_pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_state: got PC=%h addr=%h req=%b instr=%h v=%b ret=%h mis=%b to=%b h=%b, required PC=%h all else 0",
                     PC, imemAddr, imemReq, instruction, instrValid, retired, misaligned, timeout, halted, m_pc);
        else n_pass++;
        reset     = 1'b1;
        imemReady = 1'b0;
        tick();
        n_checks++;
        if ({imemReq, imemAddr, halted} !== {1'b1, RST_PC, 1'b0})
            $display("FAIL first_req: got req=%b addr=%h halted=%b, required req=1 addr=%h halted=0",
                     imemReq, imemAddr, halted, RST_PC);
        else n_pass++;
    endtask

    // One fetch/execute transaction starting in the first cycle of REQ.
    task automatic fetch_execute(input logic [31:0] instr, input int unsigned wait_cycles,
                                 input int unsigned n_stall, input logic [31:0] target);
        logic last;
        for (int unsigned w = 0; w < wait_cycles; w++) begin
            imemReady = 1'b0;
            instrIn   = $urandom;
            PCNext    = $urandom;
            stall     = 1'($urandom_range(0, 1));
            tick();
            n_checks++;
            if ({imemReq, imemAddr, timeout, halted, instrValid} !== {1'b1, m_pc, 1'b0, 1'b0, 1'b0})
                $display("FAIL req_wait: cycle %0d got req=%b addr=%h to=%b h=%b v=%b, required req=1 addr=%h to=0 h=0 v=0",
                         w, imemReq, imemAddr, timeout, halted, instrValid, m_pc);
            else n_pass++;
        end
        imemReady = 1'b1;
        instrIn   = instr;
        PCNext    = $urandom;
        stall     = 1'($urandom_range(0, 1));
        tick();
        m_instr = instr;
        if (instr == EBREAK) begin
            n_checks++;
            if ({halted, instrValid, instruction, imemReq, PC, retired} !== {1'b1, 1'b0, instr, 1'b0, m_pc, m_retired})
                $display("FAIL ebreak_halt: got h=%b v=%b instr=%h req=%b PC=%h ret=%h, required h=1 v=0 instr=%h req=0 PC=%h ret=%h",
                         halted, instrValid, instruction, imemReq, PC, retired, instr, m_pc, m_retired);
            else n_pass++;
            return;
        end
        n_checks++;
        if ({imemReq, instrValid, instruction, PC, retired, halted} !== {1'b0, 1'b1, instr, m_pc, m_retired, 1'b0})
            $display("FAIL exec_entry: got req=%b v=%b instr=%h PC=%h ret=%h h=%b, required req=0 v=1 instr=%h PC=%h ret=%h h=0",
                     imemReq, instrValid, instruction, PC, retired, halted, instr, m_pc, m_retired);
        else n_pass++;
        for (int unsigned c = 0; c < EXEC_N + n_stall; c++) begin
            last      = (c == EXEC_N + n_stall - 1);
            imemReady = 1'($urandom_range(0, 1));
            instrIn   = $urandom;
            if (c < EXEC_N - 1) stall = 1'($urandom_range(0, 1));
            else                stall = !last;
            PCNext = last ? target : $urandom;
            tick();
            if (!last) begin
                n_checks++;
                if ({imemReq, instrValid, PC, retired, halted} !== {1'b0, 1'b0, m_pc, m_retired, 1'b0})
                    $display("FAIL exec_hold: cycle %0d got req=%b v=%b PC=%h ret=%h h=%b, required req=0 v=0 PC=%h ret=%h h=0",
                             c, imemReq, instrValid, PC, retired, halted, m_pc, m_retired);
                else n_pass++;
            end else if (target[1:0] != 2'b00) begin
                m_mis = 1'b1;
                n_checks++;
                if ({halted, misaligned, imemReq, PC, retired, instrValid} !== {1'b1, 1'b1, 1'b0, m_pc, m_retired, 1'b0})
                    $display("FAIL misaligned_update: got h=%b mis=%b req=%b PC=%h ret=%h v=%b, required h=1 mis=1 req=0 PC=%h ret=%h v=0",
                             halted, misaligned, imemReq, PC, retired, instrValid, m_pc, m_retired);
                else n_pass++;
            end else begin
                m_pc      = target;
                m_retired = m_retired + 32'd1;
                n_checks++;
                if ({imemReq, imemAddr, PC, retired, instrValid, halted, misaligned}
                    !== {1'b1, m_pc, m_pc, m_retired, 1'b0, 1'b0, 1'b0})
                    $display("FAIL pc_update: got req=%b addr=%h PC=%h ret=%h v=%b h=%b mis=%b, required req=1 addr=PC=%h ret=%h v=0 h=0 mis=0",
                             imemReq, imemAddr, PC, retired, instrValid, halted, misaligned, m_pc, m_retired);
                else n_pass++;
            end
        end
    endtask

    task automatic check_frozen(input string tag, input int unsigned n_cycles);
        for (int unsigned i = 0; i < n_cycles; i++) begin
            imemReady = 1'($urandom_range(0, 1));
            instrIn   = rand_instr();
            PCNext    = {$urandom_range(0, 255), 2'b00};
            stall     = 1'($urandom_range(0, 1));
            tick();
            n_checks++;
            if ({halted, imemReq, instrValid, PC, instruction, retired, misaligned, timeout}
                !== {1'b1, 1'b0, 1'b0, m_pc, m_instr, m_retired, m_mis, m_to})
                $display("FAIL %s_frozen: got h=%b req=%b v=%b PC=%h instr=%h ret=%h mis=%b to=%b, required h=1 req=0 v=0 PC=%h instr=%h ret=%h mis=%b to=%b",
                         tag, halted, imemReq, instrValid, PC, instruction, retired, misaligned, timeout,
                         m_pc, m_instr, m_retired, m_mis, m_to);
            else n_pass++;
        end
    endtask

    task automatic test_sequential();
        test_reset(2);
        for (int unsigned i = 0; i < 3; i++) fetch_execute(rand_instr(), 0, 0, m_pc + 32'd4);
        n_checks++;
        if ({PC, retired} !== {32'h0000_000C, 32'd3})
            $display("FAIL sequential_end: got PC=%h ret=%0d, required PC=0000000c ret=3", PC, retired);
        else n_pass++;
    endtask

    task automatic test_branch();
        fetch_execute(rand_instr(), 0, 0, 32'h0000_0040);
        fetch_execute(rand_instr(), 1, 0, m_pc + 32'd4);
    endtask

    task automatic test_stall();
        fetch_execute(rand_instr(), 0, 3, m_pc + 32'd4);
        fetch_execute(rand_instr(), 2, 1, m_pc + 32'd8);
    endtask

    task automatic test_no_timeout();
        fetch_execute(rand_instr(), WAIT_N - 1, 0, m_pc + 32'd4);
        n_checks++;
        if ({timeout, halted} !== 2'b00)
            $display("FAIL no_timeout: got to=%b h=%b, required to=0 h=0", timeout, halted);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] t;
        for (int unsigned i = 0; i < 25; i++) begin
            t = $urandom;
            t[1:0] = 2'b00;
            fetch_execute(rand_instr(), $urandom_range(0, WAIT_N - 1), $urandom_range(0, 3), t);
        end
    endtask

    task automatic test_timeout();
        test_reset(1);
        fetch_execute(rand_instr(), 0, 0, 32'h0000_0100);
        for (int unsigned w = 0; w < WAIT_N - 1; w++) begin
            imemReady = 1'b0;
            instrIn   = $urandom;
            tick();
        end
        n_checks++;
        if ({imemReq, timeout, halted} !== {1'b1, 1'b0, 1'b0})
            $display("FAIL timeout_early: got req=%b to=%b h=%b, required req=1 to=0 h=0", imemReq, timeout, halted);
        else n_pass++;
        tick();
        m_to = 1'b1;
        n_checks++;
        if ({timeout, halted, imemReq, PC, retired} !== {1'b1, 1'b1, 1'b0, m_pc, m_retired})
            $display("FAIL timeout_hit: got to=%b h=%b req=%b PC=%h ret=%h, required to=1 h=1 req=0 PC=%h ret=%h",
                     timeout, halted, imemReq, PC, retired, m_pc, m_retired);
        else n_pass++;
        check_frozen("timeout", 4);
    endtask

    task automatic test_misaligned();
        test_reset(1);
        fetch_execute(rand_instr(), 0, 0, 32'h0000_0010);
        fetch_execute(rand_instr(), 0, 0, 32'h0000_0042);
        check_frozen("misaligned", 4);
    endtask

    task automatic test_ebreak();
        test_reset(1);
        fetch_execute(rand_instr(), 0, 0, 32'h0000_0020);
        fetch_execute(EBREAK, 3, 0, 32'h0);
        check_frozen("ebreak", 4);
        test_reset(1);
        fetch_execute(rand_instr(), 0, 0, m_pc + 32'd4);
    endtask

    // Reset asserted on what would be the update edge must discard the update.
    task automatic test_reset_abort();
        imemReady = 1'b1;
        instrIn   = rand_instr();
        tick();
        imemReady = 1'b0;
        stall     = 1'b0;
        tick();
        PCNext = 32'h0000_0080;
        reset  = 1'b0;
        tick();
        n_checks++;
        if ({PC, retired, imemReq, instrValid, instruction, halted} !== {RST_PC, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0})
            $display("FAIL reset_abort: got PC=%h ret=%h req=%b v=%b instr=%h h=%b, required PC=%h ret=0 req=0 v=0 instr=0 h=0",
                     PC, retired, imemReq, instrValid, instruction, halted, RST_PC);
        else n_pass++;
        test_reset(1);
    endtask

    initial begin
        reset     = 1'b0;
        PCNext    = '0;
        stall     = 1'b0;
        imemReady = 1'b0;
        instrIn   = '0;
        test_sequential();
        test_branch();
        test_stall();
        test_no_timeout();
        test_random();
        test_reset_abort();
        test_timeout();
        test_misaligned();
        test_ebreak();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
